// File: rtl/sbox_seq_ctrl_if.sv
// Handshake and S-box bus bundle for sbox_seq_ctrl.
// wAbort exists only when SBOX_SEQ_ABORT_EN is defined.
interface sbox_seq_ctrl_if;
    logic        wInValid;
    logic        wInReady;
    logic [0:47] wInData;
    logic [0:5]  wSboxIn;
    logic [2:0]  wSboxSel;
    logic [0:3]  wSboxOut;
    logic        wOutValid;
    logic        wOutReady;
    logic [0:31] wOutData;
    logic        wBusy;
`ifdef SBOX_SEQ_ABORT_EN
    logic        wAbort;
`endif

    modport master (
        output wInValid, wInData, wOutReady, wSboxOut,
`ifdef SBOX_SEQ_ABORT_EN
        output wAbort,
`endif
        input  wInReady, wSboxIn, wSboxSel, wOutValid, wOutData, wBusy
    );

    modport slave (
        input  wInValid, wInData, wOutReady, wSboxOut,
`ifdef SBOX_SEQ_ABORT_EN
        input  wAbort,
`endif
        output wInReady, wSboxIn, wSboxSel, wOutValid, wOutData, wBusy
    );
endinterface

// File: rtl/sbox_seq_ctrl.sv
// Sequences eight 6-bit chunks through one shared S-box unit.
// Optional abort input enabled by macro SBOX_SEQ_ABORT_EN.
module sbox_seq_ctrl #(
    parameter int LAT = 0
) (
    input logic            wClk,
    input logic            wReset,
    sbox_seq_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic [1:0] CLAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    state_t      state, nstate;
    logic [2:0]  idx;
    logic [1:0]  cnt;
    logic [0:47] data;
    logic [0:31] nib;
    logic        accept;
    logic        capture;
    logic        last;
    logic        kill;

    assign accept = (state == IDLE) && bus.wInValid;
    assign last   = (idx == 3'd7);

`ifdef SBOX_SEQ_ABORT_EN
    assign kill = bus.wAbort && (state != IDLE);
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        nstate        = state;
        capture       = 1'b0;
        bus.wInReady  = 1'b0;
        bus.wOutValid = 1'b0;
        bus.wBusy     = (state != IDLE);
        bus.wSboxIn   = '0;
        bus.wSboxSel  = '0;
        bus.wOutData  = '0;
        unique case (state)
            IDLE: begin
                bus.wInReady = 1'b1;
                if (bus.wInValid) nstate = ISSUE;
            end
            ISSUE: begin
                bus.wSboxIn  = data[int'(idx)*6 +: 6];
                bus.wSboxSel = idx;
                if (LAT == 0) begin
                    capture = 1'b1;
                    if (last) nstate = DONE;
                end else begin
                    nstate = WAIT;
                end
            end
            WAIT: begin
                bus.wSboxIn  = data[int'(idx)*6 +: 6];
                bus.wSboxSel = idx;
                if (cnt == CLAST) begin
                    capture = 1'b1;
                    nstate  = last ? DONE : ISSUE;
                end
            end
            DONE: begin
                bus.wOutValid = 1'b1;
                bus.wOutData  = nib;
                if (bus.wOutReady) nstate = IDLE;
            end
            default: nstate = IDLE;
        endcase
        // abort outranks a simultaneous consume in DONE
        if (kill) nstate = IDLE;
    end

    always_ff @(posedge wClk) begin
        if (wReset) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
            data  <= '0;
            nib   <= '0;
        end else begin
            state <= nstate;
            if (kill) begin
                idx  <= '0;
                cnt  <= '0;
                data <= '0;
                nib  <= '0;
            end else begin
                if (accept) begin
                    data <= bus.wInData;
                    idx  <= '0;
                    cnt  <= '0;
                end
                if (state == WAIT) cnt <= cnt + 2'd1;
                if (capture) begin
                    nib[int'(idx)*4 +: 4] <= bus.wSboxOut;
                    cnt <= '0;
                    // index parks at 7 so no ninth lookup can start
                    if (!last) idx <= idx + 3'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sbox_seq_ctrl.sv
// Directed bench for sbox_seq_ctrl with LAT=0 and LAT=2 instances.
// A DES S1..S8 model stands in for the shared S-box unit.
module tb_sbox_seq_ctrl;
    logic wClk = 1'b0;
    logic wReset;
    int   checks = 0;
    int   errors = 0;

    always #5 wClk = ~wClk;

    sbox_seq_ctrl_if i0 ();
    sbox_seq_ctrl_if i2 ();

    sbox_seq_ctrl #(.LAT(0)) dut0 (.wClk(wClk), .wReset(wReset), .bus(i0.slave));
    sbox_seq_ctrl #(.LAT(2)) dut2 (.wClk(wClk), .wReset(wReset), .bus(i2.slave));

    localparam logic [255:0] S1 = 256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D;
    localparam logic [255:0] S2 = 256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9;
    localparam logic [255:0] S3 = 256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C;
    localparam logic [255:0] S4 = 256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E;
    localparam logic [255:0] S5 = 256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453;
    localparam logic [255:0] S6 = 256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D;
    localparam logic [255:0] S7 = 256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C;
    localparam logic [255:0] S8 = 256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B;

    function automatic logic [0:3] sbox(input logic [2:0] sel, input logic [0:5] x);
        logic [255:0] t;
        int k;
        k = ({x[0], x[5]} * 16) + int'(x[1:4]);
        case (sel)
            3'd0: t = S1;
            3'd1: t = S2;
            3'd2: t = S3;
            3'd3: t = S4;
            3'd4: t = S5;
            3'd5: t = S6;
            3'd6: t = S7;
            default: t = S8;
        endcase
        return t[255 - 4*k -: 4];
    endfunction

    assign i0.wSboxOut = sbox(i0.wSboxSel, i0.wSboxIn);
    assign i2.wSboxOut = sbox(i2.wSboxSel, i2.wSboxIn);

    task automatic tick;
        @(posedge wClk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // accept one request on dut0, then count edges until wOutValid
    task automatic run0(input string tag, input logic [0:47] d, input logic [31:0] exp);
        int n;
        i0.wInValid = 1'b1;
        i0.wInData  = d;
        tick();
        i0.wInValid = 1'b0;
        n = 0;
        while (!i0.wOutValid && n < 40) begin
            chk({tag, "_sel"}, 32'(i0.wSboxSel), 32'(n));
            tick();
            n++;
        end
        chk({tag, "_edges"}, 32'(n), 32'd8);
        chk({tag, "_data"}, i0.wOutData, exp);
    endtask

    initial begin
        int n;
        int pulses;
        logic [31:0] held;
        wReset       = 1'b1;
        i0.wInValid  = 1'b0;
        i0.wInData   = '0;
        i0.wOutReady = 1'b0;
        i2.wInValid  = 1'b0;
        i2.wInData   = '0;
        i2.wOutReady = 1'b0;
`ifdef SBOX_SEQ_ABORT_EN
        i0.wAbort = 1'b0;
        i2.wAbort = 1'b0;
`endif
        tick();
        tick();
        wReset = 1'b0;

        chk("rst_inready", 32'(i0.wInReady), 32'd1);
        chk("rst_outvalid", 32'(i0.wOutValid), 32'd0);
        chk("rst_busy", 32'(i0.wBusy), 32'd0);
        chk("rst_sboxin", 32'(i0.wSboxIn), 32'd0);
        chk("rst_sboxsel", 32'(i0.wSboxSel), 32'd0);
        chk("rst_outdata", i0.wOutData, 32'd0);
        chk("rst_busy2", 32'(i2.wBusy), 32'd0);

        // LAT=0, all-zero chunks
        i0.wInValid = 1'b1;
        i0.wInData  = 48'h0;
        tick();
        i0.wInValid = 1'b0;
        chk("issue_inready", 32'(i0.wInReady), 32'd0);
        chk("issue_busy", 32'(i0.wBusy), 32'd1);
        chk("issue_outdata", i0.wOutData, 32'd0);
        n = 0;
        while (!i0.wOutValid && n < 40) begin
            chk("z0_sel", 32'(i0.wSboxSel), 32'(n));
            tick();
            n++;
        end
        chk("z0_edges", 32'(n), 32'd8);
        chk("z0_data", i0.wOutData, 32'hEFA72C4D);
        chk("z0_sboxsel_done", 32'(i0.wSboxSel), 32'd0);

        // stall in DONE with a pending request
        held = i0.wOutData;
        i0.wInValid = 1'b1;
        i0.wInData  = 48'h040000000000;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_data", i0.wOutData, held);
            chk("stall_inready", 32'(i0.wInReady), 32'd0);
            chk("stall_valid", 32'(i0.wOutValid), 32'd1);
        end
        i0.wOutReady = 1'b1;
        tick();
        i0.wOutReady = 1'b0;
        chk("consume_busy", 32'(i0.wBusy), 32'd0);
        chk("consume_valid", 32'(i0.wOutValid), 32'd0);
        chk("consume_outdata", i0.wOutData, 32'd0);
        chk("consume_inready", 32'(i0.wInReady), 32'd1);

        // pending request accepted now: chunk0 = 000001
        tick();
        i0.wInValid = 1'b0;
        chk("late_accept_busy", 32'(i0.wBusy), 32'd1);
        n = 0;
        while (!i0.wOutValid && n < 40) begin
            tick();
            n++;
        end
        chk("c1_edges", 32'(n), 32'd8);
        chk("c1_data", i0.wOutData, 32'h0FA72C4D);
        i0.wOutReady = 1'b1;
        tick();
        i0.wOutReady = 1'b0;

        // LAT=2, all-zero chunks, each select held 3 cycles
        i2.wInValid = 1'b1;
        i2.wInData  = 48'h0;
        tick();
        i2.wInValid = 1'b0;
        n = 0;
        while (!i2.wOutValid && n < 80) begin
            chk("l2_sel", 32'(i2.wSboxSel), 32'(n / 3));
            chk("l2_busy", 32'(i2.wBusy), 32'd1);
            tick();
            n++;
        end
        chk("l2_edges", 32'(n), 32'd24);
        chk("l2_data", i2.wOutData, 32'hEFA72C4D);
        i2.wOutReady = 1'b1;
        tick();
        i2.wOutReady = 1'b0;
        chk("l2_idle", 32'(i2.wBusy), 32'd0);

        // reset at the 4th ISSUE cycle
        i0.wInValid = 1'b1;
        i0.wInData  = 48'hFFFFFFFFFFFF;
        tick();
        i0.wInValid = 1'b0;
        tick();
        tick();
        tick();
        chk("pre_rst_sel", 32'(i0.wSboxSel), 32'd3);
        wReset = 1'b1;
        tick();
        wReset = 1'b0;
        chk("mid_rst_busy", 32'(i0.wBusy), 32'd0);
        chk("mid_rst_sel", 32'(i0.wSboxSel), 32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (i0.wOutValid) pulses++;
            tick();
        end
        chk("mid_rst_pulses", 32'(pulses), 32'd0);

        run0("ones", 48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
        i0.wOutReady = 1'b1;
        tick();
        i0.wOutReady = 1'b0;
        run0("msb", 48'h820820820820, 32'h40DA4917);
        i0.wOutReady = 1'b1;
        tick();
        i0.wOutReady = 1'b0;

`ifdef SBOX_SEQ_ABORT_EN
        // abort beats consume in DONE
        run0("ab", 48'h0, 32'hEFA72C4D);
        i0.wAbort    = 1'b1;
        i0.wOutReady = 1'b1;
        tick();
        i0.wAbort    = 1'b0;
        i0.wOutReady = 1'b0;
        chk("abort_done_busy", 32'(i0.wBusy), 32'd0);
        chk("abort_done_data", i0.wOutData, 32'd0);
        chk("abort_done_valid", 32'(i0.wOutValid), 32'd0);
        // abort ignored in IDLE, honoured in ISSUE
        i0.wAbort   = 1'b1;
        i0.wInValid = 1'b1;
        tick();
        i0.wInValid = 1'b0;
        chk("abort_idle_ignored", 32'(i0.wBusy), 32'd1);
        tick();
        i0.wAbort = 1'b0;
        chk("abort_issue_busy", 32'(i0.wBusy), 32'd0);
        chk("abort_issue_inready", 32'(i0.wInReady), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
